// File: rtl/bcd_scan_if.sv
// bcd_scan_if: CPU register bus plus digit/segment outputs of the scan controller
interface bcd_scan_if;
    logic        Read;
    logic        Write;
    logic [1:0]  Addr;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic [3:0]  sel;
    logic [7:0]  seg;
    modport master (output Read, Write, Addr, Write_data, input Read_data, sel, seg);
    modport slave  (input Read, Write, Addr, Write_data, output Read_data, sel, seg);
endinterface

// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: memory-mapped 4-digit seven-segment scan controller with blanking gap and raw mode
module bcd_scan_ctrl #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input logic       clk,
    input logic       reset,
    bcd_scan_if.slave bus
);
    localparam int MX = CLK_DIV > BLANK_CYCLES ? CLK_DIV : BLANK_CYCLES;
    localparam int CW = MX > 1 ? $clog2(MX) : 1;
    localparam logic [1:0] IDLE = 2'd0, SHOW = 2'd1, BLANK = 2'd2;
    localparam logic [CW-1:0] SHOW_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
    localparam logic [6:0] LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [19:0]   data;
    logic [3:0]    blank_mask;
    logic          raw, en;
    logic [1:0]    st, digit, entry_digit;
    logic [CW-1:0] cnt;
    logic [4:0]    shadow;
    logic [3:0]    sel_q;
    logic [7:0]    seg_q;
    logic          run, unused_bits;
    assign run         = en & ~raw;
    assign entry_digit = st == BLANK ? digit + 2'd1 : 2'd0;
    assign unused_bits = ^bus.Write_data[31:20];
    assign bus.sel     = sel_q;
    assign bus.seg     = seg_q;
    assign bus.Read_data = (!bus.Read || reset) ? 32'b0 :
                           bus.Addr == 2'd0 ? {12'b0, data} :
                           bus.Addr == 2'd1 ? {24'b0, blank_mask, 2'b0, raw, en} :
                           bus.Addr == 2'd2 ? {28'b0, st == SHOW, st == BLANK, digit} : 32'b0;
    // shadow is latched from the pre-write DATA, so a write never tears the digit on display
    always_ff @(posedge clk) begin
        if (reset) begin
            data       <= '0;
            blank_mask <= '0;
            raw        <= 1'b0;
            en         <= 1'b0;
            st         <= IDLE;
            digit      <= '0;
            cnt        <= '0;
            shadow     <= '0;
            sel_q      <= '0;
            seg_q      <= '0;
        end else begin
            if (bus.Write && bus.Addr == 2'd0) data <= bus.Write_data[19:0];
            if (bus.Write && bus.Addr == 2'd1) {blank_mask, raw, en} <= {bus.Write_data[7:4], bus.Write_data[1:0]};
            if (!run) begin
                st    <= IDLE;
                digit <= '0;
                cnt   <= '0;
            end else if (st == IDLE || (st == BLANK && cnt == BLANK_END)) begin
                st     <= SHOW;
                digit  <= entry_digit;
                cnt    <= '0;
                shadow <= {data[5'd16 + 5'(entry_digit)], data[{entry_digit, 2'b00} +: 4]};
            end else if (st == SHOW && cnt == SHOW_END) begin
                st  <= BLANK;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            sel_q <= raw ? data[11:8] : (st == SHOW && !blank_mask[digit]) ? 4'b1 << digit : 4'b0;
            seg_q <= raw ? data[7:0] : st == SHOW ? {shadow[4], LUT[shadow[3:0]]} : 8'b0;
        end
    end
endmodule
